// File: rtl/lsu_pkg.sv
// Shared LSU types: the per-entry load queue lifecycle state encoding.
package lsu_pkg;

  typedef enum logic [2:0] {
    INVALID   = 3'd0,
    WAIT_ADDR = 3'd1,
    READY     = 3'd2,
    FIRED     = 3'd3,
    SLEEP     = 3'd4,
    DONE      = 3'd5
  } ldq_state_t;

endpackage

// File: rtl/ldq_entry_fsm.sv
// One LDQ entry: lifecycle state plus the ROB tag of the store it sleeps on.
module ldq_entry_fsm
  import lsu_pkg::*;
#(
  parameter int ROB_TAG_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush_i,
  input  logic                     alloc_i,
  input  logic                     addr_i,
  input  logic                     fire_i,
  input  logic                     sleep_i,
  input  logic [ROB_TAG_WIDTH-1:0] sleep_rob_tag_i,
  input  logic                     bypass_i,
  input  logic                     wake_valid_i,
  input  logic [ROB_TAG_WIDTH-1:0] wake_rob_tag_i,
  input  logic                     complete_i,
  input  logic                     nack_i,
  input  logic                     free_i,
  output ldq_state_t               state_o,
  output logic [ROB_TAG_WIDTH-1:0] tag_o
);

  ldq_state_t               state_q, state_d;
  logic [ROB_TAG_WIDTH-1:0] tag_q, tag_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INVALID;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
    end
  end

  // Flush beats alloc beats every state-specific event.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    if (flush_i) begin
      state_d = INVALID;
    end else if (alloc_i) begin
      state_d = WAIT_ADDR;
      tag_d   = '0;
    end else begin
      case (state_q)
        WAIT_ADDR: if (addr_i) state_d = READY;
        READY: begin
          if (fire_i) begin
            if (sleep_i) begin
              // The tag is latched even when the same-cycle wake bypasses SLEEP.
              tag_d   = sleep_rob_tag_i;
              state_d = bypass_i ? READY : SLEEP;
            end else begin
              state_d = FIRED;
            end
          end
        end
        SLEEP: if (wake_valid_i && (wake_rob_tag_i == tag_q)) state_d = READY;
        FIRED: begin
          if (complete_i)  state_d = DONE;
          else if (nack_i) state_d = READY;
        end
        DONE:    if (free_i) state_d = INVALID;
        default: state_d = state_q;
      endcase
    end
  end

  assign state_o = state_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/load_wakeup_tracker.sv
// LDQ lifecycle tracker: decodes indexed events into one-hot per-entry strobes and publishes state masks.
module load_wakeup_tracker
  import lsu_pkg::*;
#(
  parameter int ROB_TAG_WIDTH = 32,
  parameter int LDQ_SIZE      = 32
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   alloc_valid,
  input  logic [$clog2(LDQ_SIZE)-1:0]            alloc_index,
  input  logic                                   addr_valid,
  input  logic [$clog2(LDQ_SIZE)-1:0]            addr_index,
  input  logic                                   load_fired,
  input  logic [$clog2(LDQ_SIZE)-1:0]            load_fired_ldq_index,
  input  logic                                   sleep,
  input  logic [ROB_TAG_WIDTH-1:0]               sleep_rob_tag,
  input  logic                                   forward,
  input  logic                                   wake_valid,
  input  logic [ROB_TAG_WIDTH-1:0]               wake_rob_tag,
  input  logic                                   load_complete,
  input  logic [$clog2(LDQ_SIZE)-1:0]            load_complete_index,
  input  logic                                   load_nack,
  input  logic [$clog2(LDQ_SIZE)-1:0]            load_nack_index,
  input  logic                                   free_valid,
  input  logic [$clog2(LDQ_SIZE)-1:0]            free_index,
  input  logic [LDQ_SIZE-1:0]                    flush_mask,
  output logic [LDQ_SIZE-1:0]                    ldq_ready,
  output logic [LDQ_SIZE-1:0]                    ldq_sleeping,
  output logic [LDQ_SIZE-1:0]                    ldq_done,
  output logic [LDQ_SIZE-1:0][ROB_TAG_WIDTH-1:0] ldq_sleep_tag
);

  localparam int IDX_W = $clog2(LDQ_SIZE);

  // Forwarding does not change the lifecycle; a forwarded load still waits for load_complete.
  logic unused_forward;
  assign unused_forward = forward;

  // Only the fired entry can take the bypass, so one shared comparator suffices.
  logic bypass;
  assign bypass = wake_valid && (wake_rob_tag == sleep_rob_tag);

  ldq_state_t entry_state [LDQ_SIZE];

  for (genvar i = 0; i < LDQ_SIZE; i++) begin : g_entry
    ldq_entry_fsm #(
      .ROB_TAG_WIDTH(ROB_TAG_WIDTH)
    ) u_entry (
      .clk            (clk),
      .reset_n        (reset_n),
      .flush_i        (flush_mask[i]),
      .alloc_i        (alloc_valid   && (alloc_index          == IDX_W'(i))),
      .addr_i         (addr_valid    && (addr_index           == IDX_W'(i))),
      .fire_i         (load_fired    && (load_fired_ldq_index == IDX_W'(i))),
      .sleep_i        (sleep),
      .sleep_rob_tag_i(sleep_rob_tag),
      .bypass_i       (bypass),
      .wake_valid_i   (wake_valid),
      .wake_rob_tag_i (wake_rob_tag),
      .complete_i     (load_complete && (load_complete_index  == IDX_W'(i))),
      .nack_i         (load_nack     && (load_nack_index      == IDX_W'(i))),
      .free_i         (free_valid    && (free_index           == IDX_W'(i))),
      .state_o        (entry_state[i]),
      .tag_o          (ldq_sleep_tag[i])
    );

    assign ldq_ready[i]    = (entry_state[i] == READY);
    assign ldq_sleeping[i] = (entry_state[i] == SLEEP);
    assign ldq_done[i]     = (entry_state[i] == DONE);
  end

endmodule

// File: tb/tb_load_wakeup_tracker.sv
// Directed scoreboard bench for load_wakeup_tracker: the driver pushes hand-computed masks, a monitor compares them.
module tb_load_wakeup_tracker;

  localparam int TW = 32;
  localparam int NE = 32;

  logic              clk;
  logic              reset_n;
  logic              alloc_valid;
  logic [4:0]        alloc_index;
  logic              addr_valid;
  logic [4:0]        addr_index;
  logic              load_fired;
  logic [4:0]        load_fired_ldq_index;
  logic              sleep;
  logic [TW-1:0]     sleep_rob_tag;
  logic              forward;
  logic              wake_valid;
  logic [TW-1:0]     wake_rob_tag;
  logic              load_complete;
  logic [4:0]        load_complete_index;
  logic              load_nack;
  logic [4:0]        load_nack_index;
  logic              free_valid;
  logic [4:0]        free_index;
  logic [NE-1:0]     flush_mask;
  logic [NE-1:0]     ldq_ready;
  logic [NE-1:0]     ldq_sleeping;
  logic [NE-1:0]     ldq_done;
  logic [NE-1:0][TW-1:0] ldq_sleep_tag;

  load_wakeup_tracker #(.ROB_TAG_WIDTH(TW), .LDQ_SIZE(NE)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .alloc_valid         (alloc_valid),
    .alloc_index         (alloc_index),
    .addr_valid          (addr_valid),
    .addr_index          (addr_index),
    .load_fired          (load_fired),
    .load_fired_ldq_index(load_fired_ldq_index),
    .sleep               (sleep),
    .sleep_rob_tag       (sleep_rob_tag),
    .forward             (forward),
    .wake_valid          (wake_valid),
    .wake_rob_tag        (wake_rob_tag),
    .load_complete       (load_complete),
    .load_complete_index (load_complete_index),
    .load_nack           (load_nack),
    .load_nack_index     (load_nack_index),
    .free_valid          (free_valid),
    .free_index          (free_index),
    .flush_mask          (flush_mask),
    .ldq_ready           (ldq_ready),
    .ldq_sleeping        (ldq_sleeping),
    .ldq_done            (ldq_done),
    .ldq_sleep_tag       (ldq_sleep_tag)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] cyc_cnt = '0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 16'd1;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [15:0]   due;
    logic [NE-1:0] ready;
    logic [NE-1:0] sleeping;
    logic [NE-1:0] done;
    logic          chk_tag;
    logic [4:0]    tag_idx;
    logic [TW-1:0] tag_val;
  } exp_t;
  localparam int W = $bits(exp_t);
  logic [W-1:0] exp_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are registered, so each expectation is due right after the edge that latched its inputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_t'(exp_q[0]);
        if (e.due > cyc_cnt) break;
        void'(exp_q.pop_front());
        check("ready", ldq_ready, e.ready);
        check("sleeping", ldq_sleeping, e.sleeping);
        check("done", ldq_done, e.done);
        if (e.chk_tag) check($sformatf("tag[%0d]", e.tag_idx), ldq_sleep_tag[e.tag_idx], e.tag_val);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic idle();
    alloc_valid = 0; alloc_index = '0; addr_valid = 0; addr_index = '0;
    load_fired = 0; load_fired_ldq_index = '0; sleep = 0; sleep_rob_tag = '0; forward = 0;
    wake_valid = 0; wake_rob_tag = '0; load_complete = 0; load_complete_index = '0;
    load_nack = 0; load_nack_index = '0; free_valid = 0; free_index = '0; flush_mask = '0;
  endtask

  // Caller sets inputs at posedge+1; this records the expected masks after the coming edge.
  task automatic cyc(input logic [31:0] er, input logic [31:0] es, input logic [31:0] ed,
                     input logic ct, input logic [4:0] ti, input logic [31:0] tv);
    exp_t e;
    e.due = cyc_cnt + 16'd1; e.ready = er; e.sleeping = es; e.done = ed;
    e.chk_tag = ct; e.tag_idx = ti; e.tag_val = tv;
    exp_q.push_back(W'(e));
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic fire(input logic [4:0] idx, input logic slp, input logic [31:0] tag);
    load_fired = 1; load_fired_ldq_index = idx; sleep = slp; sleep_rob_tag = tag;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got simulation still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1;
    check("reset_ready", ldq_ready, 32'h0);
    check("reset_sleeping", ldq_sleeping, 32'h0);
    check("reset_done", ldq_done, 32'h0);

    // Basic lifecycle on entry 3 (forward asserted to show it has no effect)
    alloc_valid = 1; alloc_index = 3;                  cyc(32'h0, 32'h0, 32'h0, 1, 3, 32'h0);
    addr_valid = 1; addr_index = 3;                    cyc(32'h8, 32'h0, 32'h0, 0, 0, 32'h0);
    fire(3, 0, 32'h0); forward = 1;                    cyc(32'h0, 32'h0, 32'h0, 0, 0, 32'h0);
    load_complete = 1; load_complete_index = 3;        cyc(32'h0, 32'h0, 32'h8, 0, 0, 32'h0);
    free_valid = 1; free_index = 3;                    cyc(32'h0, 32'h0, 32'h0, 0, 0, 32'h0);

    // Sleep and wake on entry 5
    alloc_valid = 1; alloc_index = 5;                  cyc(32'h0, 32'h0, 32'h0, 0, 0, 32'h0);
    addr_valid = 1; addr_index = 5;                    cyc(32'h20, 32'h0, 32'h0, 0, 0, 32'h0);
    fire(5, 1, 32'h1A);                                cyc(32'h0, 32'h20, 32'h0, 1, 5, 32'h1A);
    wake_valid = 1; wake_rob_tag = 32'h1B;             cyc(32'h0, 32'h20, 32'h0, 1, 5, 32'h1A);
    wake_valid = 1; wake_rob_tag = 32'h1A;             cyc(32'h20, 32'h0, 32'h0, 0, 0, 32'h0);

    // Wakeup bypass on entry 7
    alloc_valid = 1; alloc_index = 7;                  cyc(32'h20, 32'h0, 32'h0, 0, 0, 32'h0);
    addr_valid = 1; addr_index = 7;                    cyc(32'hA0, 32'h0, 32'h0, 0, 0, 32'h0);
    fire(7, 1, 32'h09); wake_valid = 1; wake_rob_tag = 32'h09;
                                                       cyc(32'hA0, 32'h0, 32'h0, 1, 7, 32'h09);

    // Multi-wake on entries 1 and 2, then nack on 1
    alloc_valid = 1; alloc_index = 1;                  cyc(32'hA0, 32'h0, 32'h0, 0, 0, 32'h0);
    alloc_valid = 1; alloc_index = 2; addr_valid = 1; addr_index = 1;
                                                       cyc(32'hA2, 32'h0, 32'h0, 0, 0, 32'h0);
    addr_valid = 1; addr_index = 2;                    cyc(32'hA6, 32'h0, 32'h0, 0, 0, 32'h0);
    fire(1, 1, 32'h40);                                cyc(32'hA4, 32'h2, 32'h0, 1, 1, 32'h40);
    fire(2, 1, 32'h40);                                cyc(32'hA0, 32'h6, 32'h0, 1, 2, 32'h40);
    wake_valid = 1; wake_rob_tag = 32'h40;             cyc(32'hA6, 32'h0, 32'h0, 0, 0, 32'h0);
    fire(1, 0, 32'h0);                                 cyc(32'hA4, 32'h0, 32'h0, 0, 0, 32'h0);
    load_nack = 1; load_nack_index = 1;                cyc(32'hA6, 32'h0, 32'h0, 0, 0, 32'h0);

    // Complete and nack on the same entry: complete wins
    fire(2, 0, 32'h0);                                 cyc(32'hA2, 32'h0, 32'h0, 0, 0, 32'h0);
    load_complete = 1; load_complete_index = 2; load_nack = 1; load_nack_index = 2;
                                                       cyc(32'hA2, 32'h0, 32'h4, 0, 0, 32'h0);

    // Flush beats complete on entry 4
    alloc_valid = 1; alloc_index = 4;                  cyc(32'hA2, 32'h0, 32'h4, 0, 0, 32'h0);
    addr_valid = 1; addr_index = 4;                    cyc(32'hB2, 32'h0, 32'h4, 0, 0, 32'h0);
    fire(4, 0, 32'h0);                                 cyc(32'hA2, 32'h0, 32'h4, 0, 0, 32'h0);
    flush_mask = 32'h10; load_complete = 1; load_complete_index = 4;
                                                       cyc(32'hA2, 32'h0, 32'h4, 0, 0, 32'h0);

    // Free of a non-DONE entry is ignored; wake with no sleeper changes nothing
    free_valid = 1; free_index = 5; wake_valid = 1; wake_rob_tag = 32'h09;
                                                       cyc(32'hA2, 32'h0, 32'h4, 0, 0, 32'h0);

    // Put entry 5 to sleep, then asynchronous reset mid-cycle
    fire(5, 1, 32'h33);                                cyc(32'h82, 32'h20, 32'h4, 1, 5, 32'h33);
    @(posedge clk);
    #4;
    reset_n = 0;
    #1;
    check("async_ready", ldq_ready, 32'h0);
    check("async_sleeping", ldq_sleeping, 32'h0);
    check("async_done", ldq_done, 32'h0);
    check("async_tag5", ldq_sleep_tag[5], 32'h0);
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
    wake_valid = 1; wake_rob_tag = 32'h33;             cyc(32'h0, 32'h0, 32'h0, 1, 5, 32'h0);

    @(posedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_wakeup_tracker.md
Name: load_wakeup_tracker

Overview:
- Per-entry lifecycle tracker for the load queue (LDQ). It sits directly downstream of the load store-dependence checker and consumes that checker's same-cycle sleep, sleep_rob_tag and forward outputs for the fired load.
- A load put to sleep holds the ROB tag of the store it waits on. It wakes when that store's data is broadcast as valid.
- It publishes per-entry ready, sleeping and done masks. The load fire arbiter uses the ready mask; commit and flush logic use the done mask.

Parameters:
- ROB_TAG_WIDTH, 32, width of ROB tags.
- LDQ_SIZE, 32, number of LDQ entries; must be a power of two.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- alloc_valid  input  1  dispatch allocates an LDQ entry.
- alloc_index  input  $clog2(LDQ_SIZE)  entry being allocated.
- addr_valid  input  1  AGU wrote the address of an entry.
- addr_index  input  $clog2(LDQ_SIZE)  entry whose address was written.
- load_fired  input  1  a load fired this cycle.
- load_fired_ldq_index  input  $clog2(LDQ_SIZE)  fired entry.
- sleep  input  1  dependence checker: fired load must sleep.
- sleep_rob_tag  input  ROB_TAG_WIDTH  ROB tag of the blocking store.
- forward  input  1  dependence checker: data is forwarded (informational only).
- wake_valid  input  1  a store's data became valid this cycle.
- wake_rob_tag  input  ROB_TAG_WIDTH  ROB tag of that store.
- load_complete  input  1  cache or forward data returned for an entry.
- load_complete_index  input  $clog2(LDQ_SIZE)  entry that completed.
- load_nack  input  1  cache rejected the request; the load must replay.
- load_nack_index  input  $clog2(LDQ_SIZE)  entry that was rejected.
- free_valid  input  1  commit frees an entry.
- free_index  input  $clog2(LDQ_SIZE)  entry being freed.
- flush_mask  input  LDQ_SIZE  entries to squash this cycle.
- ldq_ready  output  LDQ_SIZE  entry is in READY.
- ldq_sleeping  output  LDQ_SIZE  entry is in SLEEP.
- ldq_done  output  LDQ_SIZE  entry is in DONE.
- ldq_sleep_tag  output  LDQ_SIZE x ROB_TAG_WIDTH  latched sleep tag per entry.

Behaviour:
- Each entry holds a registered state (INVALID, WAIT_ADDR, READY, FIRED, SLEEP, DONE) and a tag register.
- All outputs are pure decodes of registered state, so they change the cycle after the causing event.
- Reset (reset_n low, asynchronous):
  - all states INVALID, all tags 0.
  - all outputs therefore 0.
- Transitions, evaluated per entry each cycle, highest priority first:
  1. flush_mask[i] = 1 -> INVALID from any state. Every other event on that entry in that cycle is ignored.
  2. alloc_valid and alloc_index == i -> WAIT_ADDR; tag cleared to 0. Upstream guarantees the entry is INVALID; if it is not, alloc overrides.
  3. WAIT_ADDR with addr_valid and addr_index == i -> READY.
  4. READY with load_fired and load_fired_ldq_index == i:
     - sleep = 0 -> FIRED (forward or cache access).
     - sleep = 1 -> SLEEP and tag <= sleep_rob_tag.
     - sleep = 1 and wake_valid with wake_rob_tag == sleep_rob_tag in the same cycle -> READY (wakeup bypass); tag is still latched.
  5. SLEEP with wake_valid and wake_rob_tag == tag -> READY. The broadcast may wake several entries in the same cycle.
  6. FIRED with load_complete and load_complete_index == i -> DONE.
  7. FIRED with load_nack and load_nack_index == i -> READY. If both load_complete and load_nack name the same entry, load_complete wins.
  8. DONE with free_valid and free_index == i -> INVALID.
- Events on an entry in a state other than the one listed for that event are ignored; state is held.
- Indices are ignored when their valid bit is 0.
- The tag register is written only on a transition into SLEEP (or into READY via the wakeup bypass) and on alloc; otherwise it holds its value.
- Tags compare on full ROB_TAG_WIDTH equality; no age arithmetic is done in this block.
- If reset_n is asserted mid-operation, all state is lost immediately and no pending wake is remembered.

Decomposition:
- Package lsu_pkg holds ldq_state_t, a 3-bit enum with INVALID=0, WAIT_ADDR=1, READY=2, FIRED=3, SLEEP=4, DONE=5.
- Sub-module ldq_entry_fsm holds one entry's state and tag register and takes pre-decoded per-entry event bits.
- The top level decodes indices into one-hot event vectors and instantiates ldq_entry_fsm LDQ_SIZE times in a generate loop.

Test Plan:
- Basic lifecycle: alloc 3, addr 3, fire 3 with sleep=0, complete 3, free 3 -> ldq_ready[3] is 1 after addr and 0 after fire; ldq_done[3] is 1 after complete; all masks are 0 after free.
- Sleep and wake: fire 5 with sleep=1 and sleep_rob_tag=0x1A -> ldq_sleeping[5]=1 and ldq_sleep_tag[5]=0x1A. A wake with tag 0x1B causes no change. A wake with tag 0x1A -> ldq_ready[5]=1 on the next cycle.
- Wakeup bypass: fire 7 with sleep=1 and tag 0x09, plus wake_valid with tag 0x09 in the same cycle -> entry 7 goes directly to READY and ldq_sleeping[7] is never 1.
- Multi-wake and nack: entries 1 and 2 both sleeping on tag 0x40; a single wake with tag 0x40 -> both become READY. Then fire 1 followed by load_nack on 1 -> entry 1 returns to READY.
- Flush priority: entry 4 FIRED; in the same cycle flush_mask[4]=1 and load_complete on 4 -> entry 4 becomes INVALID, not DONE.
- Asynchronous reset: drop reset_n mid-cycle while entries are in SLEEP and DONE -> all masks go to 0 immediately, without waiting for a clock edge.
